// File: rtl/cksum_sched.sv
// cksum_sched: descriptor FIFO plus issue FSM in front of the single cksum engine.
// One job in flight at a time; start drops for one cycle between jobs so the engine returns to FREE.
module cksum_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_field_start_i,
    input  logic [31:0]      req_field_len_i,
    input  logic [31:0]      req_dst_start_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output logic             cks_start_o,
    output logic [31:0]      cks_field_start_o,
    output logic [31:0]      cks_field_len_o,
    output logic [31:0]      cks_dst_start_o,
    input  logic             cks_ready_i,
    output logic             done_o,
    output logic [TAG_W-1:0] done_tag_o,
    output logic             idle_o,
    output logic [15:0]      jobs_done_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [31:0]      fifo_fs_q  [DEPTH];
    logic [31:0]      fifo_len_q [DEPTH];
    logic [31:0]      fifo_dst_q [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    state_t           state_q;
    state_t           state_d;
    logic             start_q;
    logic             start_d;
    logic [31:0]      fs_q;
    logic [31:0]      fs_d;
    logic [31:0]      len_q;
    logic [31:0]      len_d;
    logic [31:0]      dst_q;
    logic [31:0]      dst_d;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_d;
    logic             done_q;
    logic             done_d;
    logic [TAG_W-1:0] done_tag_q;
    logic [TAG_W-1:0] done_tag_d;
    logic             idle_q;
    logic             idle_d;
    logic [15:0]      jobs_done_q;
    logic [15:0]      jobs_done_d;

    logic             push_s;
    logic             pop_s;
    logic             head_avail_s;

    // No bypass: readiness depends only on the registered occupancy, so a pop never frees a slot early.
    assign req_ready_o  = ~rst & (count_q != CNT_FULL) & ~flush_i;
    assign push_s       = req_valid_i & req_ready_o;
    assign head_avail_s = (count_q != CNT_ZERO) & ~flush_i;

    // Descriptor storage and pointers; flush drops everything queued but not yet popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_fs_q[i]  <= 32'd0;
                fifo_len_q[i] <= 32'd0;
                fifo_dst_q[i] <= 32'd0;
                fifo_tag_q[i] <= {TAG_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_fs_q[wr_ptr_q]  <= req_field_start_i;
                fifo_len_q[wr_ptr_q] <= req_field_len_i;
                fifo_dst_q[wr_ptr_q] <= req_dst_start_i;
                fifo_tag_q[wr_ptr_q] <= req_tag_i;
                wr_ptr_q             <= wr_ptr_q + PTR_ONE;
            end
            if (flush_i) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = CNT_ZERO;
        end else if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Issue FSM: ISSUE masks the previous job's ready, which the engine only clears on that edge.
    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        fs_d        = fs_q;
        len_d       = len_q;
        dst_d       = dst_q;
        tag_d       = tag_q;
        done_d      = 1'b0;
        done_tag_d  = done_tag_q;
        jobs_done_d = jobs_done_q;
        pop_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_avail_s) begin
                    pop_s   = 1'b1;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cks_ready_i) begin
                    start_d     = 1'b0;
                    done_d      = 1'b1;
                    done_tag_d  = tag_q;
                    jobs_done_d = jobs_done_q + 16'd1;
                    state_d     = S_RELEASE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RELEASE: begin
                if (head_avail_s) begin
                    pop_s   = 1'b1;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (pop_s) begin
            fs_d  = fifo_fs_q[rd_ptr_q];
            len_d = fifo_len_q[rd_ptr_q];
            dst_d = fifo_dst_q[rd_ptr_q];
            tag_d = fifo_tag_q[rd_ptr_q];
        end else begin
            tag_d = tag_q;
        end
    end

    assign idle_d = (count_d == CNT_ZERO) && (state_d == S_IDLE);

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            fs_q        <= 32'd0;
            len_q       <= 32'd0;
            dst_q       <= 32'd0;
            tag_q       <= {TAG_W{1'b0}};
            done_q      <= 1'b0;
            done_tag_q  <= {TAG_W{1'b0}};
            idle_q      <= 1'b1;
            jobs_done_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            fs_q        <= fs_d;
            len_q       <= len_d;
            dst_q       <= dst_d;
            tag_q       <= tag_d;
            done_q      <= done_d;
            done_tag_q  <= done_tag_d;
            idle_q      <= idle_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign cks_start_o       = start_q;
    assign cks_field_start_o = fs_q;
    assign cks_field_len_o   = len_q;
    assign cks_dst_start_o   = dst_q;
    assign done_o            = done_q;
    assign done_tag_o        = done_tag_q;
    assign idle_o            = idle_q;
    assign jobs_done_o       = jobs_done_q;

endmodule

// File: tb/tb_cksum_sched.sv
// Bench for cksum_sched: a fixed single-job table, directed multi-cycle sequences and random traffic,
// all checked against a queue-based model of the scheduler plus a small behavioural engine.
module tb_cksum_sched;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0]      fs;
        logic [31:0]      len;
        logic [31:0]      dst;
        logic [TAG_W-1:0] tag;
    } job_t;

    typedef struct {
        logic             vld;
        logic             rdy;
        logic             exp_start;
        logic             exp_done;
        logic [TAG_W-1:0] exp_tag;
        logic             exp_idle;
        logic [15:0]      exp_jobs;
        logic [31:0]      exp_fs;
        logic [31:0]      exp_len;
        logic [31:0]      exp_dst;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      req_field_start_i;
    logic [31:0]      req_field_len_i;
    logic [31:0]      req_dst_start_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             flush_i;
    logic             cks_start_o;
    logic [31:0]      cks_field_start_o;
    logic [31:0]      cks_field_len_o;
    logic [31:0]      cks_dst_start_o;
    logic             cks_ready_i;
    logic             done_o;
    logic [TAG_W-1:0] done_tag_o;
    logic             idle_o;
    logic [15:0]      jobs_done_o;

    cksum_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_field_start_i(req_field_start_i), .req_field_len_i(req_field_len_i),
        .req_dst_start_i(req_dst_start_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
        .cks_start_o(cks_start_o), .cks_field_start_o(cks_field_start_o),
        .cks_field_len_o(cks_field_len_o), .cks_dst_start_o(cks_dst_start_o),
        .cks_ready_i(cks_ready_i), .done_o(done_o), .done_tag_o(done_tag_o),
        .idle_o(idle_o), .jobs_done_o(jobs_done_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending jobs, job held at the engine, and the visible outputs.
    job_t             jq[$];
    job_t             m_cur;
    job_t             m_fields;
    logic             m_start;
    logic             m_done;
    int               m_age;
    logic [TAG_W-1:0] m_tag;
    logic [15:0]      m_jobs;
    logic             m_idle;

    // Engine model: stale ready lingers until the first edge that sees a new start.
    logic e_busy;
    int   e_cnt;
    int   e_lat;
    logic e_rand;

    logic             last_acc;
    logic             saw_full;
    int               idx;
    job_t             cur_j;
    vec_t             tbl [7];
    logic [TAG_W-1:0] dut_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        jq.delete();
        m_cur    = '0;
        m_fields = '0;
        m_start  = 1'b0;
        m_done   = 1'b0;
        m_age    = 0;
        m_tag    = '0;
        m_jobs   = 16'd0;
        m_idle   = 1'b1;
    endtask

    task automatic check_model();
        check("start", cks_start_o, m_start);
        check("field_start", cks_field_start_o, m_fields.fs);
        check("field_len", cks_field_len_o, m_fields.len);
        check("dst_start", cks_dst_start_o, m_fields.dst);
        check("done", done_o, m_done);
        if (m_done) check("done_tag", done_tag_o, m_tag);
        check("idle", idle_o, m_idle);
        check("jobs_done", jobs_done_o, m_jobs);
    endtask

    function automatic job_t rand_job(input logic [TAG_W-1:0] tag);
        job_t r;
        r.fs  = $urandom;
        r.len = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1500));
        r.dst = $urandom;
        r.tag = tag;
        return r;
    endfunction

    // One clock: called at a negedge, drives inputs, advances the model, checks after the next edge.
    task automatic cycle(input logic v, input job_t j, input logic fl);
        logic exp_rdy;
        logic pushed;
        logic complete;
        logic pop;
        if (cks_start_o) begin
            if (!e_busy) begin
                e_busy = 1'b1;
                e_cnt  = e_rand ? int'($urandom_range(0, 3)) : e_lat;
            end else if (e_cnt == 0) begin
                cks_ready_i = 1'b1;
            end else begin
                cks_ready_i = 1'b0;
                e_cnt--;
            end
        end else begin
            e_busy = 1'b0;
            if (e_rand && $urandom_range(0, 3) == 0) cks_ready_i = 1'b0;
        end
        req_valid_i       = v;
        req_field_start_i = j.fs;
        req_field_len_i   = j.len;
        req_dst_start_i   = j.dst;
        req_tag_i         = j.tag;
        flush_i           = fl;
        #1;
        exp_rdy = (jq.size() < DEPTH) && !fl;
        check("req_ready", req_ready_o, exp_rdy);
        last_acc = req_ready_o && v;
        if (v && !req_ready_o) saw_full = 1'b1;
        pushed   = v && exp_rdy;
        complete = m_start && (m_age >= 1) && cks_ready_i;
        pop      = !m_start && (jq.size() > 0) && !fl;
        m_done   = complete;
        if (complete) begin
            m_start = 1'b0;
            m_tag   = m_cur.tag;
            m_jobs  = m_jobs + 16'd1;
        end else if (m_start) begin
            m_age++;
        end
        if (pop) begin
            m_cur    = jq.pop_front();
            m_fields = m_cur;
            m_start  = 1'b1;
            m_age    = 0;
        end
        if (fl) jq.delete();
        if (pushed) jq.push_back(j);
        m_idle = (jq.size() == 0) && !m_start && !m_done;
        @(posedge clk);
        @(negedge clk);
        if (done_o) dut_log.push_back(done_tag_o);
        check_model();
    endtask

    task automatic drain();
        job_t z;
        z = '0;
        for (int k = 0; k < 200 && !idle_o; k++) cycle(1'b0, z, 1'b0);
        check("drain_idle", idle_o, 1'b1);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        cks_ready_i = 1'b0;
        e_busy      = 1'b0;
        e_rand      = 1'b0;
        saw_full    = 1'b0;
        dut_log.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0, 32'h0,  32'd0,  32'h0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 32'h10, 32'd20, 32'h1A};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 32'h10, 32'd20, 32'h1A};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0, 32'h10, 32'd20, 32'h1A};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 16'd1, 32'h10, 32'd20, 32'h1A};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 16'd1, 32'h10, 32'd20, 32'h1A};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 16'd1, 32'h10, 32'd20, 32'h1A};

        rst               = 1'b1;
        req_valid_i       = 1'b0;
        req_field_start_i = 32'h10;
        req_field_len_i   = 32'd20;
        req_dst_start_i   = 32'h1A;
        req_tag_i         = 4'd3;
        flush_i           = 1'b0;
        cks_ready_i       = 1'b0;
        e_busy            = 1'b0;
        e_cnt             = 0;
        e_lat             = 0;
        e_rand            = 1'b0;
        saw_full          = 1'b0;
        last_acc          = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_start", cks_start_o, 1'b0);
        check("rst_fields", {cks_field_start_o, cks_field_len_o}, 64'd0);
        check("rst_dst", cks_dst_start_o, 32'd0);
        check("rst_done", {done_o, done_tag_o}, 5'd0);
        check("rst_idle", idle_o, 1'b1);
        check("rst_jobs", jobs_done_o, 16'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", req_ready_o, 1'b1);

        // Single job, cycle by cycle from the table.
        for (int i = 0; i < 7; i++) begin
            req_valid_i = tbl[i].vld;
            cks_ready_i = tbl[i].rdy;
            @(posedge clk);
            @(negedge clk);
            check("tbl_start", cks_start_o, tbl[i].exp_start);
            check("tbl_done", done_o, tbl[i].exp_done);
            check("tbl_done_tag", done_tag_o, tbl[i].exp_tag);
            check("tbl_idle", idle_o, tbl[i].exp_idle);
            check("tbl_jobs", jobs_done_o, tbl[i].exp_jobs);
            check("tbl_fs", cks_field_start_o, tbl[i].exp_fs);
            check("tbl_len", cks_field_len_o, tbl[i].exp_len);
            check("tbl_dst", cks_dst_start_o, tbl[i].exp_dst);
        end

        // Back-to-back tags 1,2,3 with immediate ready, so ready is stale in every ISSUE cycle.
        do_reset();
        e_lat = 0;
        for (int t = 1; t <= 3; t++) cycle(1'b1, rand_job(TAG_W'(t)), 1'b0);
        drain();
        check("b2b_count", dut_log.size(), 3);
        for (int k = 0; k < 3; k++) check("b2b_tag", (k < dut_log.size()) ? dut_log[k] : 4'hF, k + 1);
        check("b2b_jobs", jobs_done_o, 16'd3);

        // Full: DEPTH+1 pushes behind a long-running first job.
        do_reset();
        e_lat = 15;
        idx   = 0;
        for (int c = 0; c < 80 && idx < DEPTH + 2; c++) begin
            cur_j = rand_job(TAG_W'(idx));
            cycle(1'b1, cur_j, 1'b0);
            if (last_acc) idx++;
        end
        drain();
        check("full_backpressure", saw_full, 1'b1);
        check("full_count", dut_log.size(), DEPTH + 2);
        for (int k = 0; k < DEPTH + 2; k++) check("full_order", (k < dut_log.size()) ? dut_log[k] : 4'hF, k);
        check("full_jobs", jobs_done_o, 16'(DEPTH + 2));

        // Flush with three queued, one in flight, and a simultaneous push.
        do_reset();
        e_lat = 10;
        for (int t = 8; t < 12; t++) cycle(1'b1, rand_job(TAG_W'(t)), 1'b0);
        cycle(1'b1, rand_job(4'd12), 1'b1);
        check("flush_push_refused", last_acc, 1'b0);
        drain();
        check("flush_count", dut_log.size(), 1);
        check("flush_tag", (dut_log.size() > 0) ? dut_log[0] : 4'hF, 4'd8);
        check("flush_jobs", jobs_done_o, 16'd1);

        // Async reset mid-WAIT.
        do_reset();
        e_lat = 0;
        cycle(1'b1, rand_job(4'd5), 1'b0);
        drain();
        e_lat = 6;
        cycle(1'b1, rand_job(4'd6), 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, rand_job(4'd0), 1'b0);
        check("pre_reset_start", cks_start_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_start", cks_start_o, 1'b0);
        check("arst_done", done_o, 1'b0);
        check("arst_jobs", jobs_done_o, 16'd0);
        check("arst_idle", idle_o, 1'b1);
        check("arst_fs", cks_field_start_o, 32'd0);
        e_busy      = 1'b0;
        cks_ready_i = 1'b0;
        req_valid_i = 1'b0;
        model_reset();
        dut_log.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, rand_job(4'd7), 1'b0);
        drain();
        check("arst_after_jobs", jobs_done_o, 16'd1);
        check("arst_after_tag", (dut_log.size() > 0) ? dut_log[0] : 4'hF, 4'd7);

        // Random traffic with random engine latency and occasional flushes.
        do_reset();
        e_rand = 1'b1;
        for (int c = 0; c < 600; c++) begin
            cycle(1'($urandom_range(0, 1)), rand_job(TAG_W'($urandom_range(0, 15))),
                  ($urandom_range(0, 24) == 0));
        end
        drain();

        // Counter wrap from a preloaded 0xFFFF.
        do_reset();
        e_lat = 1;
        force dut.jobs_done_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.jobs_done_q;
        m_jobs = 16'hFFFF;
        check("wrap_preload", jobs_done_o, 16'hFFFF);
        cycle(1'b1, rand_job(4'd9), 1'b0);
        drain();
        check("wrap_jobs", jobs_done_o, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cksum_sched.md
Name: cksum_sched

Overview:
- Job scheduler in front of the single `cksum` engine.
- Pipeline stages (parser/deparser actions) push checksum job descriptors into a DEPTH-entry FIFO.
- The scheduler issues jobs one at a time through the engine's level-held start/ready handshake. It holds the descriptor fields stable for the whole job and reports completion per job with its tag.
- It also guarantees the engine returns to FREE between jobs, and never mistakes a stale ready from the previous job for completion of the current one.

Parameters:
- DEPTH, 4, descriptor FIFO entries (power of 2, ≥2).
- TAG_W, 4, job tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  job descriptor valid
- req_ready_o  out  1  FIFO can accept (not full and not flush_i)
- req_field_start_i  in  32  checksummed field start address
- req_field_len_i  in  32  field length in bytes
- req_dst_start_i  in  32  checksum destination address
- req_tag_i  in  TAG_W  job tag
- flush_i  in  1  discard all queued (not in-flight) jobs
- cks_start_o  out  1  to engine start_i
- cks_field_start_o  out  32  to engine field_start_i
- cks_field_len_o  out  32  to engine field_len_i
- cks_dst_start_o  out  32  to engine dst_field_start_i
- cks_ready_i  in  1  from engine cksum_ready_o
- done_o  out  1  one-cycle completion pulse
- done_tag_o  out  TAG_W  tag of the completed job; valid with done_o
- idle_o  out  1  FIFO empty and state IDLE
- jobs_done_o  out  16  completed-job counter, wraps at 0xFFFF→0

Behaviour:
- Reset (async) values:
  - FIFO empty; state IDLE.
  - cks_start_o=0; cks_* fields=0.
  - done_o=0; done_tag_o=0; jobs_done_o=0; idle_o=1.
  - req_ready_o=1 once rst is low.
- Push: accepted on an edge with req_valid_i & req_ready_o. There is no bypass; a full FIFO stays full even if a pop occurs the same cycle.
- Flush: flush_i high at an edge empties the FIFO. A simultaneous push is not accepted (req_ready_o is low). The in-flight job is unaffected and still completes and reports done.
- FSM, all outputs registered:
  - IDLE: if FIFO non-empty → pop head into cks_* regs, cks_start_o←1, go ISSUE.
  - ISSUE (exactly 1 cycle): ignore cks_ready_i, which may be stale high from the previous job; the engine clears it on this edge. Go WAIT.
  - WAIT: hold cks_start_o=1 and fields stable. When cks_ready_i=1 → cks_start_o←0, done_o←1, done_tag_o←tag, jobs_done_o+1, go RELEASE.
  - RELEASE (1 cycle, cks_start_o=0, lets the engine go DONE→FREE): done_o←0. If FIFO non-empty → pop, cks_start_o←1, go ISSUE. Else go IDLE.
- Field outputs keep the last job's values in IDLE; they change only on pop.
- Latency:
  - Push at edge E0 into an empty idle scheduler → cks_start_o high after E0+1.
  - Engine cks_ready_i high → done_o high the following cycle.
  - Back-to-back jobs: start deasserted for exactly 1 cycle between jobs.
- Ordering: strict FIFO; one job in flight maximum.
- idle_o = (count==0) & (state==IDLE), registered.
- Reset mid-job: everything returns to reset values immediately; no done is reported. The engine shares rst.
- Zero-length jobs are passed through unmodified (the engine writes 0xFFFF).

Test Plan:
- Single job: push {start=0x10, len=20, dst=0x1A, tag=3} to the idle scheduler → cks_start_o rises 1 cycle after the push edge and fields hold until ready; one done_o pulse with done_tag_o=3; jobs_done_o=1; idle_o returns to 1.
- Back-to-back: push tags 1, 2, 3 in consecutive cycles → each cks_start_o deasserted for exactly 1 cycle between jobs; stale ready in each ISSUE cycle is not counted as done; done tags appear in order 1, 2, 3; jobs_done_o=3.
- Full: push DEPTH+1 jobs while the first is in flight → req_ready_o=0 after DEPTH queued; the extra push is not accepted until a pop; all accepted jobs complete.
- Flush: 3 queued jobs plus 1 in flight, pulse flush_i with a simultaneous req_valid_i → only the in-flight job reports done; the push is not accepted; FIFO empty; idle_o=1 after RELEASE.
- Async reset asserted mid-WAIT → cks_start_o=0, done_o=0, jobs_done_o=0, idle_o=1 immediately, without waiting for a clock edge; a new job after reset runs normally.
- Counter wrap: preload by running jobs until jobs_done_o=0xFFFF, complete one more → jobs_done_o=0x0000.
